// File: rtl/scan_mem_bank.sv
// Scan-loadable register-file memory: processor read/write port plus one serial
// scan chain through every cell; top cells drive io_out, address DEPTH reads io_in.
module scan_mem_bank #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 15,
    parameter int IO_REGS = 1
) (
    input  logic                                       clk_in,
    input  logic                                       rst_in,
    input  logic                                       scan_enable_in,
    input  logic                                       scan_in,
    output logic                                       scan_out,
    input  logic                                       proc_en_in,
    input  logic [ADDR_W-1:0]                          addr_in,
    input  logic                                       we_in,
    input  logic [DATA_W-1:0]                          wdata_in,
    output logic [DATA_W-1:0]                          rdata_out,
    input  logic [DATA_W-1:0]                          io_in,
    output logic [((IO_REGS > 0) ? IO_REGS*DATA_W : 1)-1:0] io_out,
    output logic                                       addr_err_out,
    output logic [$clog2(DEPTH*DATA_W+1)-1:0]          scan_count_out,
    output logic                                       scan_done_out
);

    localparam int CHAIN_LEN = DEPTH * DATA_W;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

    logic [CHAIN_LEN-1:0] chain_q, chain_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic [DATA_W-1:0]    sync1_q, sync2_q;

    always_comb begin
        chain_d = chain_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (scan_enable_in) begin
            chain_d = {scan_in, chain_q[CHAIN_LEN-1:1]};
            if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            // Dropping enable discards any partial exchange.
            cnt_d = '0;
            if (proc_en_in) begin
                if (addr_in < ADDR_W'(DEPTH)) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (addr_in == ADDR_W'(i)) begin
                            rdata_d = chain_q[i*DATA_W +: DATA_W];
                            if (we_in) begin
                                chain_d[i*DATA_W +: DATA_W] = wdata_in;
                            end
                        end
                    end
                end else if (addr_in == ADDR_W'(DEPTH)) begin
                    rdata_d = sync2_q;
                end else begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            chain_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            chain_q <= chain_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            sync1_q <= io_in;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (IO_REGS > 0) begin : g_io
            for (genvar k = 0; k < IO_REGS; k++) begin : g_cell
                assign io_out[k*DATA_W +: DATA_W] =
                    chain_q[(DEPTH-1-k)*DATA_W +: DATA_W];
            end
        end else begin : g_noio
            assign io_out = '0;
        end
    endgenerate

    assign scan_out       = chain_q[0];
    assign rdata_out      = rdata_q;
    assign addr_err_out   = err_q;
    assign scan_count_out = cnt_q;
    assign scan_done_out  = done_q;

endmodule

// File: tb/tb_scan_mem_bank.sv
// Randomised and directed bench for scan_mem_bank against a bit-queue model;
// a second DEPTH=14 instance covers the out-of-range address path.
module tb_scan_mem_bank;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       scan_enable_in;
    logic       scan_in;
    logic       proc_en_in;
    logic [3:0] addr_in;
    logic       we_in;
    logic [7:0] wdata_in;
    logic [7:0] io_in;

    logic       scan_out, err, done;
    logic [7:0] rdata, io_out;
    logic [6:0] count;

    logic       scan_out14, err14, done14;
    logic [7:0] rdata14, io_out14;
    logic [6:0] count14;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_in = ~clk_in;

    scan_mem_bank dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .scan_enable_in(scan_enable_in), .scan_in(scan_in),
        .scan_out(scan_out), .proc_en_in(proc_en_in),
        .addr_in(addr_in), .we_in(we_in), .wdata_in(wdata_in),
        .rdata_out(rdata), .io_in(io_in), .io_out(io_out),
        .addr_err_out(err), .scan_count_out(count),
        .scan_done_out(done)
    );

    scan_mem_bank #(.DEPTH(14)) dut14 (
        .clk_in(clk_in), .rst_in(rst_in),
        .scan_enable_in(scan_enable_in), .scan_in(scan_in),
        .scan_out(scan_out14), .proc_en_in(proc_en_in),
        .addr_in(addr_in), .we_in(we_in), .wdata_in(wdata_in),
        .rdata_out(rdata14), .io_in(io_in), .io_out(io_out14),
        .addr_err_out(err14), .scan_count_out(count14),
        .scan_done_out(done14)
    );

    // Reference model: chain as a bit queue, index 0 = bit nearest scan_out.
    bit         chain[$];
    logic [7:0] m_rdata;
    logic       m_err, m_done;
    int         m_run;
    logic [7:0] m_s1, m_s2;

    function automatic logic [7:0] mcell(int i);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = chain[i*8+j];
        return r;
    endfunction

    task automatic set_cell(int i, logic [7:0] w);
        for (int j = 0; j < 8; j++) chain[i*8+j] = w[j];
    endtask

    task automatic model_reset();
        chain.delete();
        for (int i = 0; i < 120; i++) chain.push_back(1'b0);
        m_rdata = '0; m_err = 0; m_done = 0; m_run = 0;
        m_s1 = '0; m_s2 = '0;
    endtask

    task automatic model_edge();
        m_err  = 0;
        m_done = 0;
        if (scan_enable_in) begin
            void'(chain.pop_front());
            chain.push_back(scan_in);
            m_run++;
            m_done = (m_run % 120 == 0);
        end else begin
            m_run = 0;
            if (proc_en_in) begin
                if (addr_in < 15) begin
                    m_rdata = mcell(int'(addr_in));
                    if (we_in) set_cell(int'(addr_in), wdata_in);
                end else begin
                    m_rdata = m_s2;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = io_in;
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("scan_out", 32'(scan_out), 32'(chain[0]));
        check("rdata", 32'(rdata), 32'(m_rdata));
        check("err", 32'(err), 32'(m_err));
        check("count", 32'(count), 32'(m_run % 120));
        check("done", 32'(done), 32'(m_done));
        check("io_out", 32'(io_out), 32'(mcell(14)));
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        scan_enable_in = 0; proc_en_in = 0; we_in = 0;
    endtask

    task automatic access(logic [3:0] a, logic w, logic [7:0] d);
        scan_enable_in = 0; proc_en_in = 1; addr_in = a;
        we_in = w; wdata_in = d;
        step();
    endtask

    logic [119:0] v;
    logic [7:0]   b;
    int           ndone, last_done;

    initial begin
        rst_in = 1; scan_enable_in = 0; scan_in = 0; proc_en_in = 0;
        addr_in = 0; we_in = 0; wdata_in = 0; io_in = 0;
        model_reset();
        #12;
        check("rst_rdata", 32'(rdata), 0);
        check("rst_count", 32'(count), 0);
        check("rst_io", 32'(io_out), 0);
        check("rst_scan", 32'(scan_out), 0);
        check("rst_err14", 32'(err14), 0);
        @(negedge clk_in);
        rst_in = 0;
        io_in  = 8'h5A;
        idle();
        repeat (3) step();

        // Write/read and io address
        access(4'd5, 1, 8'h3C);
        check("wr_same_cyc", 32'(rdata), 32'h00);
        access(4'd5, 0, 8'h00);
        check("rd_after_wr", 32'(rdata), 32'h3C);
        access(4'd15, 0, 8'h00);
        check("io_read", 32'(rdata), 32'h5A);
        access(4'd0, 1, 8'h22);
        access(4'd15, 1, 8'h77);
        check("io_wr_rdata", 32'(rdata), 32'h5A);
        check("io_wr_noerr", 32'(err), 0);
        check("err14_pulse", 32'(err14), 1);
        check("err14_rdata", 32'(rdata14), 0);
        idle();
        step();
        check("err14_clear", 32'(err14), 0);
        access(4'd0, 0, 8'h00);
        check("err14_cell0", 32'(rdata14), 32'h22);
        access(4'd5, 0, 8'h00);
        check("err14_cell5", 32'(rdata14), 32'h3C);
        access(4'd15, 0, 8'h00);
        check("io_nochg", 32'(rdata), 32'h5A);

        // Scan load
        v = '0;
        v[8 +: 8]   = 8'hE1;
        v[112 +: 8] = 8'hF0;
        ndone = 0;
        for (int k = 0; k < 120; k++) begin
            scan_enable_in = 1; scan_in = v[k];
            step();
            if (done) ndone++;
        end
        idle();
        check("load_done_cnt", 32'(ndone), 1);
        check("load_io_out", 32'(io_out), 32'hF0);
        access(4'd1, 0, 8'h00);
        check("load_cell1", 32'(rdata), 32'hE1);

        // Scan unload
        access(4'd3, 1, 8'hA5);
        b = '0;
        for (int k = 0; k < 120; k++) begin
            if (k >= 24 && k < 32) b[k-24] = scan_out;
            scan_enable_in = 1; scan_in = 0;
            step();
        end
        check("unload_byte", 32'(b), 32'hA5);
        for (int a = 0; a < 15; a++) begin
            access(4'(a), 0, 8'h00);
            check("unload_zero", 32'(rdata), 0);
        end

        // Partial scan then full exchange; writes during scan ignored
        proc_en_in = 1; we_in = 1; addr_in = 4'd2; wdata_in = 8'hFF;
        for (int k = 0; k < 50; k++) begin
            scan_enable_in = 1; scan_in = 1'($urandom);
            step();
        end
        check("partial_cnt", 32'(count), 50);
        scan_enable_in = 0; proc_en_in = 0; we_in = 0;
        step();
        ndone = 0; last_done = -1;
        proc_en_in = 1; we_in = 1;
        for (int k = 0; k < 120; k++) begin
            scan_enable_in = 1; scan_in = 1'($urandom);
            step();
            if (done) begin ndone++; last_done = k; end
        end
        idle();
        check("partial_done_cnt", 32'(ndone), 1);
        check("partial_done_at", 32'(last_done), 119);

        // Reset mid-shift
        for (int k = 0; k < 37; k++) begin
            scan_enable_in = 1; scan_in = 1'($urandom);
            step();
        end
        check("pre_rst_cnt", 32'(count), 37);
        rst_in = 1;
        model_reset();
        #1;
        check("mid_rst_cnt", 32'(count), 0);
        check("mid_rst_io", 32'(io_out), 0);
        check("mid_rst_scan", 32'(scan_out), 0);
        check("mid_rst_rdata", 32'(rdata), 0);
        check("mid_rst_done", 32'(done), 0);
        idle();
        @(negedge clk_in);
        rst_in = 0;
        for (int a = 0; a < 15; a++) begin
            access(4'(a), 0, 8'h00);
            check("post_rst_cell", 32'(rdata), 0);
        end

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            scan_enable_in = ($urandom_range(0, 3) == 0);
            scan_in    = 1'($urandom);
            proc_en_in = 1'($urandom);
            we_in      = 1'($urandom);
            addr_in    = 4'($urandom);
            wdata_in   = 8'($urandom);
            if ($urandom_range(0, 15) == 0) io_in = 8'($urandom);
            step();
        end
        // Long scan burst to wrap the counter several times
        for (int k = 0; k < 250; k++) begin
            scan_enable_in = 1; scan_in = 1'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
